// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter with leading-zero mask.
// One input bit is consumed per enabled clock; the result is held stable between conversions.
module bin_to_bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     sig_mask
);
    localparam int CW = IN_W > 1 ? $clog2(IN_W) : 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_IN = (IN_W >= 64) ? '1 : (64'd1 << IN_W) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_IN) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for IN_W");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     shreg_q, shreg_d;
    logic [4*DIGITS-1:0] scr_q, scr_d, bcd_q, bcd_d, adj, shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d, acc;
    logic [DIGITS-1:0]   mask_q, mask_d, mask_new;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            mask_q  <= DIGITS'(1);
        end else if (en) begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = (cnt_q == '0) ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Nibbles never exceed 9, so the 4-bit add-3 cannot carry into the next digit.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        shifted  = {adj[4*DIGITS-2:0], shreg_q[IN_W-1]};
        acc      = 1'b0;
        mask_new = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc         = acc | (|shifted[4*i +: 4]);
            mask_new[i] = acc | (i == 0);
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    scr_d   = '0;
                    cnt_d   = CW'(IN_W - 1);
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                scr_d   = shifted;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bcd_d  = shifted;
                    mask_d = mask_new;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign sig_mask = mask_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vectors with a scoreboard queue; a negedge monitor
// pops the expected bcd/sig_mask whenever done is presented.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy, done;
    logic [19:0] bcd;
    logic [4:0]  sig_mask;

    int checks = 0;
    int errors = 0;
    logic [24:0] sb[$];

    bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) dut (
        .clk(clk), .reset(rst_n), .en(en), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .sig_mask(sig_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bcd", 32'(bcd), 32'(e[24:5]));
                chk("sig_mask", 32'(sig_mask), 32'(e[4:0]));
            end
        end
    end

    // Assumes the caller sits just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] b, input logic [19:0] eb, input logic [4:0] em, input bit push);
        start = 1'b1;
        bin   = b;
        if (push) sb.push_back({eb, em});
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int base, input int exp);
        int  n;
        bit  busy_gap;
        n = base;
        busy_gap = 0;
        while (!done && n < 60) begin
            if (!busy) busy_gap = 1;
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n), 32'(exp));
        chk("busy_held", 32'(busy_gap), 32'd0);
        chk("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_mask", 32'(sig_mask), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'd0, 20'h00000, 5'b00001, 1);
        wait_done("lat_zero", 0, 16);
        @(posedge clk); #1;

        issue(16'hFFFF, 20'h65535, 5'b11111, 1);
        wait_done("lat_ffff", 0, 16);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("bcd_hold", 32'(bcd), 32'h65535);

        issue(16'd1234, 20'h01234, 5'b01111, 1);
        repeat (5) begin @(posedge clk); #1; end
        en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_frozen", 32'(busy), 32'd1);
        en = 1'b1;
        wait_done("lat_en_gap", 8, 19);
        @(posedge clk); #1;

        issue(16'd42, 20'h00042, 5'b00011, 1);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1;
        bin   = 16'd999;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("lat_ignore_start", 4, 16);
        repeat (20) begin @(posedge clk); #1; end
        chk("idle_after_ignore", 32'(busy), 32'd0);

        issue(16'd500, 20'h0, 5'b0, 0);
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_bcd", 32'(bcd), 32'd0);
        chk("arst_mask", 32'(sig_mask), 32'd1);
        #2 rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("no_done_after_abort", 32'(sb.size()), 32'd0);

        issue(16'd7, 20'h00007, 5'b00001, 1);
        wait_done("lat_seven", 0, 16);
        @(posedge clk); #1;

        issue(16'd10, 20'h00010, 5'b00011, 1);
        wait_done("lat_ten", 0, 16);
        issue(16'd9, 20'h00009, 5'b00001, 1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        wait_done("lat_b2b", 0, 16);
        @(posedge clk); #1;

        issue(16'd9999, 20'h09999, 5'b01111, 1);
        wait_done("lat_9999", 0, 16);
        @(posedge clk); #1;
        issue(16'd10000, 20'h10000, 5'b11111, 1);
        wait_done("lat_10000", 0, 16);
        @(posedge clk); #1;
        issue(16'd100, 20'h00100, 5'b00111, 1);
        wait_done("lat_100", 0, 16);
        repeat (3) begin @(posedge clk); #1; end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
